mul5_share_feeder: RTL and testbench
====================================

Name: mul5_share_feeder

Overview:
- Upstream stage for the 6-share masked multiplier Mul5. Accepts one unmasked bit pair (in_x, in_y) per transaction over a valid/ready handshake.
- Draws fresh randomness from an internal 32-bit LFSR and Boolean-encodes each bit into 6 shares.
- Supplies the 5 fresh refresh bits r that Mul5 consumes, and holds all outputs stable until the downstream stage accepts them.

Parameters:
- NSHARE, 6, shares per masked bit (fixed for Mul5; other values unsupported).
- NRAND, 5, refresh bits per multiplication.
- SEED, 32'hACE1_0001, LFSR reset value (must be nonzero).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  unmasked operand pair is valid.
- in_ready  out  1  block can accept an operand pair.
- in_x  in  1  unmasked operand x.
- in_y  in  1  unmasked operand y.
- seed_load  in  1  load seed_in into the LFSR.
- seed_in  in  32  new LFSR seed.
- out_valid  out  1  x/y/r shares valid.
- out_ready  in  1  downstream (Mul5 wrapper) accepts the shares.
- x  out  6  shares of x, to Mul5.x.
- y  out  6  shares of y, to Mul5.y.
- r  out  5  fresh refresh bits, to Mul5.r.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, LFSR=SEED.
  - x=0, y=0, r=0, out_valid=0.
  - in_ready=1 once in IDLE.
- LFSR: Fibonacci, state s[31:0].
  - One step computes fb = s[31]^s[21]^s[1]^s[0] and sets s <= {s[30:0], fb}; the step's output bit is fb.
  - Each "draw" is 5 unrolled steps in one cycle, giving bits b0..b4 in step order.
  - The LFSR advances only in GEN states; it never advances in IDLE or HOLD.
- FSM states: IDLE -> GX -> GY -> GR -> HOLD -> IDLE.
  - IDLE:
    - in_ready=1.
    - On in_valid=1 at the edge, latch in_x and in_y into internal regs and go to GX.
  - GX:
    - Draw; x[k] <= b_k for k=0..4.
    - x[5] <= in_x_reg ^ b0^b1^b2^b3^b4.
    - Go to GY.
  - GY: same as GX, writing y[0..5] from in_y_reg. Go to GR.
  - GR: draw; r[k] <= b_k. Go to HOLD and set out_valid <= 1.
  - HOLD:
    - out_valid=1; x, y and r are held constant.
    - On out_ready=1 at the edge: out_valid <= 0, go to IDLE.
- Timing:
  - Latency from the accepting edge to out_valid=1 is 3 cycles.
  - Minimum transaction period is 5 cycles.
  - No new operand is accepted while in GX..HOLD (in_ready=0).
- Handshake rules:
  - in_ready is a combinational decode of state==IDLE only; it must not depend on in_valid.
  - out_valid never drops without out_ready.
- Invariants:
  - XOR of x[5:0] equals the accepted in_x; same for y.
  - Every transaction uses 15 previously unused LFSR bits.
  - A share register is written only in its own GEN state.
- seed_load:
  - Honoured only in IDLE: LFSR <= seed_in, or 32'h1 if seed_in==0. It takes priority over in_valid in the same cycle, so in_valid waits.
  - Ignored in all other states; the operation in flight is never corrupted.
- Reset mid-operation: returns to the reset state immediately and drops the operation in flight; no partial shares are exposed (out_valid=0).
- out_ready while not in HOLD: ignored.

Decomposition:
- Shared package mask_pkg:
  - constants NSHARE=6, NRAND=5, LFSR_W=32, tap positions, default SEED.
  - FSM state enum {IDLE, GX, GY, GR, HOLD}.
- Sub-module lfsr5_step:
  - purely combinational 5-step unroll.
  - input s, outputs s_next and b[4:0].
  - reused by later masked-gate feeders.

Test Plan:
- Reset: assert rst mid-simulation -> x=y=0, r=0, out_valid=0, in_ready=1 in the same cycle, without waiting for a clock edge.
- Known vector: seed_load with 32'h0000_0001 in IDLE, then in_x=1, in_y=0 accepted -> out_valid=1 exactly 3 cycles later with x=6'h0D, y=6'h1B, r=5'h16, LFSR=32'h0000_DB6D.
- Share correctness: 1000 random (in_x, in_y) transactions vs a Python LFSR model -> shares match; XOR of x shares = in_x and XOR of y shares = in_y every time.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD -> x, y, r and the LFSR unchanged, in_ready=0; release -> out_valid=0 and in_ready=1 on the next cycle.
- Seed gating:
  - seed_load in GY -> ignored, outputs match the unreseeded model.
  - seed_load with seed_in=0 in IDLE -> LFSR=32'h1.
  - seed_load and in_valid together -> seed loads, operand accepted the following cycle.
- Reset mid-op: assert rst in GR -> out_valid stays 0, LFSR=SEED; the next transaction matches the model from SEED.

Source files
------------

// File: rtl/mask_pkg.sv
// mask_pkg: shared constants and FSM state type for the masked-gate feeders.
// Holds share/refresh counts, LFSR width, tap positions and the default seed.
`timescale 1ns/1ps
package mask_pkg;

    localparam int NSHARE = 6;
    localparam int NRAND  = 5;
    localparam int LFSR_W = 32;

    // Fibonacci feedback taps: fb = s[31]^s[21]^s[1]^s[0]
    localparam int TAP0 = 31;
    localparam int TAP1 = 21;
    localparam int TAP2 = 1;
    localparam int TAP3 = 0;

    localparam logic [LFSR_W-1:0] DEF_SEED = 32'hACE1_0001;

    typedef enum logic [2:0] {
        IDLE,
        GX,
        GY,
        GR,
        HOLD
    } state_e;

endpackage

// File: rtl/lfsr5_step.sv
// lfsr5_step: five unrolled Fibonacci LFSR steps in one combinational pass.
// Ports: s (current state), s_next (state after 5 steps), b (bits, b[0] first).
`timescale 1ns/1ps
module lfsr5_step
    import mask_pkg::*;
(
    input  logic [LFSR_W-1:0] s,
    output logic [LFSR_W-1:0] s_next,
    output logic [NRAND-1:0]  b
);

    always_comb begin
        logic [LFSR_W-1:0] t;
        t = s;
        b = '0;
        for (int k = 0; k < NRAND; k++) begin
            b[k] = t[TAP0] ^ t[TAP1] ^ t[TAP2] ^ t[TAP3];
            t    = {t[LFSR_W-2:0], b[k]};
        end
        s_next = t;
    end

endmodule

// File: rtl/mul5_share_feeder.sv
// mul5_share_feeder: Boolean-masks one (x, y) bit pair into 6 shares each and
// supplies 5 refresh bits for Mul5, all drawn from an internal 32-bit LFSR.
// Ports: clk, rst (async high); in_valid/in_ready/in_x/in_y operand handshake;
// seed_load/seed_in reseed (IDLE only); out_valid/out_ready with x, y, r.
`timescale 1ns/1ps
module mul5_share_feeder #(
    parameter int          NSHARE = 6,
    parameter int          NRAND  = 5,
    parameter logic [31:0] SEED   = 32'hACE1_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_x,
    input  logic              in_y,
    input  logic              seed_load,
    input  logic [31:0]       seed_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NSHARE-1:0] x,
    output logic [NSHARE-1:0] y,
    output logic [NRAND-1:0]  r
);

    import mask_pkg::*;

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_nx;
    logic [NRAND-1:0]  bits;
    logic [NSHARE-1:0] x_q, x_d, y_q, y_d;
    logic [NRAND-1:0]  r_q, r_d;
    logic              xin_q, xin_d, yin_q, yin_d;
    logic              ov_q, ov_d;

    lfsr5_step u_step (
        .s      (lfsr_q),
        .s_next (lfsr_nx),
        .b      (bits)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            xin_q   <= 1'b0;
            yin_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            xin_q   <= xin_d;
            yin_q   <= yin_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        xin_d   = xin_q;
        yin_d   = yin_q;
        ov_d    = ov_q;
        unique case (state_q)
            IDLE: begin
                // Reseed wins over a new operand; the operand waits a cycle.
                if (seed_load) begin
                    lfsr_d = (seed_in == '0) ? 32'h1 : seed_in;
                end else if (in_valid) begin
                    xin_d   = in_x;
                    yin_d   = in_y;
                    state_d = GX;
                end
            end
            GX: begin
                // Top share closes the XOR so all six recombine to in_x.
                lfsr_d  = lfsr_nx;
                x_d     = {xin_q ^ (^bits), bits};
                state_d = GY;
            end
            GY: begin
                lfsr_d  = lfsr_nx;
                y_d     = {yin_q ^ (^bits), bits};
                state_d = GR;
            end
            GR: begin
                lfsr_d  = lfsr_nx;
                r_d     = bits;
                ov_d    = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ov_q;
    assign x         = x_q;
    assign y         = y_q;
    assign r         = r_q;

endmodule

// File: tb/tb_mul5_share_feeder.sv
// tb_mul5_share_feeder: directed and random transactions checked against a
// bit-serial LFSR reference model plus hand-computed literal vectors.
`timescale 1ns/1ps
module tb_mul5_share_feeder;

    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_x, in_y;
    logic        seed_load;
    logic [31:0] seed_in;
    logic        out_valid, out_ready;
    logic [5:0]  x, y;
    logic [4:0]  r;

    int passed = 0;
    int total  = 0;

    logic [31:0] m_lfsr;
    logic [5:0]  exp_x, exp_y;
    logic [4:0]  exp_r;
    logic        exp_bx, exp_by;
    logic        exp_live = 1'b0;
    logic [5:0]  last_x, last_y;
    logic [4:0]  last_r;
    logic [31:0] last_lfsr;

    always #5 clk = ~clk;

    mul5_share_feeder #(.NSHARE(6), .NRAND(5), .SEED(SEED)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .r         (r)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference LFSR: one bit per call, straight from the recurrence.
    task automatic draw(output logic bv);
        bv = m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0];
        m_lfsr = {m_lfsr[30:0], bv};
    endtask

    task automatic model_encode(input logic v, output logic [5:0] sh);
        logic bv;
        sh = '0;
        for (int k = 0; k < 5; k++) begin
            draw(bv);
            sh[k] = bv;
        end
        sh[5] = v ^ sh[0] ^ sh[1] ^ sh[2] ^ sh[3] ^ sh[4];
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("exp_live", 32'(exp_live), 1);
            if (exp_live) begin
                chk("x_shares", 32'(x), 32'(exp_x));
                chk("y_shares", 32'(y), 32'(exp_y));
                chk("r_bits", 32'(r), 32'(exp_r));
                chk("x_xor", 32'(^x), 32'(exp_bx));
                chk("y_xor", 32'(^y), 32'(exp_by));
                chk("busy_ready", 32'(in_ready), 0);
            end
        end
    end

    task automatic load_seed(input logic [31:0] v);
        @(negedge clk);
        seed_load = 1'b1;
        seed_in   = v;
        @(posedge clk); #1;
        seed_load = 1'b0;
        m_lfsr = (v == 0) ? 32'h1 : v;
        chk("seed_lfsr", dut.lfsr_q, m_lfsr);
        chk("seed_idle", 32'(in_ready), 1);
    endtask

    // mode 0: normal, 1: seed_load pulsed in GY, 2: reset asserted in GR
    task automatic transact(input logic bx, input logic by,
                            input int hold, input int mode);
        int n;
        logic acc;
        logic [5:0] rs;
        @(negedge clk);
        in_x = bx;
        in_y = by;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            acc = in_ready && !seed_load;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 32'(acc), 1);
            return;
        end
        exp_bx = bx;
        exp_by = by;
        model_encode(bx, exp_x);
        model_encode(by, exp_y);
        model_encode(1'b0, rs);
        exp_r = rs[4:0];
        exp_live = 1'b1;
        n = 0;
        while (n < 10) begin
            if (mode == 1 && n == 1) begin
                seed_load = 1'b1;
                seed_in = 32'h1234_5678;
            end
            if (mode == 1 && n == 2) seed_load = 1'b0;
            if (mode == 2 && n == 2) begin
                chk("gr_ov", 32'(out_valid), 0);
                rst = 1'b1;
                #1;
                chk("rst_ov", 32'(out_valid), 0);
                chk("rst_x", 32'(x), 0);
                chk("rst_y", 32'(y), 0);
                chk("rst_r", 32'(r), 0);
                chk("rst_ready", 32'(in_ready), 1);
                chk("rst_lfsr", dut.lfsr_q, SEED);
                m_lfsr = SEED;
                exp_live = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("rst_stay_ov", 32'(out_valid), 0);
                end
                return;
            end
            if (out_valid) break;
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 3);
        chk("lfsr_after", dut.lfsr_q, m_lfsr);
        last_x = x;
        last_y = y;
        last_r = r;
        last_lfsr = dut.lfsr_q;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_ready", 32'(in_ready), 0);
            chk("bp_lfsr", dut.lfsr_q, m_lfsr);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_live = 1'b0;
        chk("rel_valid", 32'(out_valid), 0);
        chk("rel_ready", 32'(in_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_x = 1'b0;
        in_y = 1'b0;
        seed_load = 1'b0;
        seed_in = '0;
        out_ready = 1'b0;
        m_lfsr = SEED;
        repeat (2) @(negedge clk);
        chk("init_ov", 32'(out_valid), 0);
        chk("init_x", 32'(x), 0);
        chk("init_y", 32'(y), 0);
        chk("init_r", 32'(r), 0);
        chk("init_ready", 32'(in_ready), 1);
        chk("init_lfsr", dut.lfsr_q, SEED);
        rst = 1'b0;

        load_seed(32'h0000_0001);
        transact(1'b1, 1'b0, 0, 0);
        chk("kv_x", 32'(last_x), 32'h0D);
        chk("kv_y", 32'(last_y), 32'h1B);
        chk("kv_r", 32'(last_r), 32'h16);
        chk("kv_lfsr", last_lfsr, 32'h0000_DB6D);
        chk("kv_model_x", 32'(exp_x), 32'h0D);
        chk("kv_model_r", 32'(exp_r), 32'h16);

        transact(1'b1, 1'b1, 10, 0);

        load_seed(32'h0);
        transact(1'b0, 1'b1, 0, 0);

        transact(1'b1, 1'b0, 2, 1);
        transact(1'b0, 1'b0, 0, 0);

        @(negedge clk);
        seed_load = 1'b1;
        seed_in = 32'hDEAD_BEEF;
        in_x = 1'b1;
        in_y = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        m_lfsr = 32'hDEAD_BEEF;
        chk("combo_lfsr", dut.lfsr_q, 32'hDEAD_BEEF);
        chk("combo_ready", 32'(in_ready), 1);
        transact(1'b1, 1'b1, 1, 0);

        transact(1'b1, 1'b1, 0, 2);
        transact(1'b1, 1'b0, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            transact(1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
